// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int XADDR  = 5;
  localparam int OPLEN  = 7;

  localparam logic [OPLEN-1:0] L_OP = 7'b0000011;

  typedef enum logic {
    S_RUN = 1'b0,
    S_MEM = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl.sv
// Stall/flush/redirect sequencing for the 5-stage core, with a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [XADDR-1:0]  i_rs1_addr_id,
  input  logic [XADDR-1:0]  i_rs2_addr_id,
  input  logic              i_rs1_used_id,
  input  logic              i_rs2_used_id,
  input  logic [OPLEN-1:0]  i_opcode_ex,
  input  logic [XADDR-1:0]  i_rd_addr_ex,
  input  logic              i_rd_ex_wr_en,
  input  logic              i_redirect_ex,
  input  logic              i_trap,
  input  logic              i_mem_req_valid,
  input  logic              i_mem_req_complete,
  input  logic              i_cnt_clr,
  output logic              or_stall_if,
  output logic              or_stall_id,
  output logic              or_stall_ex,
  output logic              or_stall_mem,
  output logic              or_flush_id,
  output logic              or_flush_ex,
  output logic              or_redirect,
  output logic [CNT_W-1:0]  or_stall_cnt
);

  hz_state_e state, state_nxt;
  logic      trap_pend, trap_pend_nxt;
  logic      lu, mem_wait, take_redir;

  // A load in EX feeding the ID instruction cannot be forwarded in time.
  assign lu = (i_opcode_ex == L_OP) && i_rd_ex_wr_en && (i_rd_addr_ex != '0) &&
              ((i_rs1_used_id && (i_rs1_addr_id == i_rd_addr_ex)) ||
               (i_rs2_used_id && (i_rs2_addr_id == i_rd_addr_ex)));

  assign mem_wait   = i_mem_req_valid && !i_mem_req_complete;
  assign take_redir = i_trap || i_redirect_ex || (state == S_MEM && trap_pend);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_RUN;
      trap_pend    <= 1'b0;
      or_stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      trap_pend <= trap_pend_nxt;
      if (i_cnt_clr)
        or_stall_cnt <= '0;
      else if (or_stall_if && (or_stall_cnt != {CNT_W{1'b1}}))
        or_stall_cnt <= or_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    trap_pend_nxt = trap_pend;
    unique case (state)
      S_RUN: begin
        if (mem_wait) begin
          state_nxt = S_MEM;
          if (i_trap) trap_pend_nxt = 1'b1;
        end
      end
      S_MEM: begin
        if (!i_mem_req_complete) begin
          if (i_trap) trap_pend_nxt = 1'b1;
        end else begin
          state_nxt     = S_RUN;
          trap_pend_nxt = 1'b0;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    or_stall_if  = 1'b0;
    or_stall_id  = 1'b0;
    or_stall_ex  = 1'b0;
    or_stall_mem = 1'b0;
    or_flush_id  = 1'b0;
    or_flush_ex  = 1'b0;
    or_redirect  = 1'b0;
    // In S_MEM the wait ends on complete alone; afterwards it behaves like S_RUN.
    if ((state == S_RUN && mem_wait) || (state == S_MEM && !i_mem_req_complete)) begin
      or_stall_if  = 1'b1;
      or_stall_id  = 1'b1;
      or_stall_ex  = 1'b1;
      or_stall_mem = 1'b1;
    end else if (take_redir) begin
      or_redirect = 1'b1;
      or_flush_id = 1'b1;
      or_flush_ex = 1'b1;
    end else if (lu) begin
      or_stall_if = 1'b1;
      or_stall_id = 1'b1;
      or_flush_ex = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: default-width and 4-bit counter instances share stimulus.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [XADDR-1:0] rs1, rs2, rd;
  logic             rs1_used, rs2_used, wr_en, redir_ex, trap, mvalid, mdone, clr;
  logic [OPLEN-1:0] op;

  logic s_if, s_id, s_ex, s_mem, f_id, f_ex, redir;
  logic s_if4, s_id4, s_ex4, s_mem4, f_id4, f_ex4, redir4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
  logic [6:0]  obs;

  assign obs = {s_if, s_id, s_ex, s_mem, f_id, f_ex, redir};

  hazard_ctrl #(.CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rs1_addr_id(rs1), .i_rs2_addr_id(rs2),
    .i_rs1_used_id(rs1_used), .i_rs2_used_id(rs2_used), .i_opcode_ex(op),
    .i_rd_addr_ex(rd), .i_rd_ex_wr_en(wr_en), .i_redirect_ex(redir_ex), .i_trap(trap),
    .i_mem_req_valid(mvalid), .i_mem_req_complete(mdone), .i_cnt_clr(clr),
    .or_stall_if(s_if), .or_stall_id(s_id), .or_stall_ex(s_ex), .or_stall_mem(s_mem),
    .or_flush_id(f_id), .or_flush_ex(f_ex), .or_redirect(redir), .or_stall_cnt(cnt16));

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rs1_addr_id(rs1), .i_rs2_addr_id(rs2),
    .i_rs1_used_id(rs1_used), .i_rs2_used_id(rs2_used), .i_opcode_ex(op),
    .i_rd_addr_ex(rd), .i_rd_ex_wr_en(wr_en), .i_redirect_ex(redir_ex), .i_trap(trap),
    .i_mem_req_valid(mvalid), .i_mem_req_complete(mdone), .i_cnt_clr(clr),
    .or_stall_if(s_if4), .or_stall_id(s_id4), .or_stall_ex(s_ex4), .or_stall_mem(s_mem4),
    .or_flush_id(f_id4), .or_flush_ex(f_ex4), .or_redirect(redir4), .or_stall_cnt(cnt4));

  // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, redirect}
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] ALLST = 7'b1111000;
  localparam logic [6:0] REDIR = 7'b0000111;
  localparam logic [6:0] LU    = 7'b1100010;

  typedef struct { string tag; logic [6:0] exp; } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic idle();
    rs1 = '0; rs2 = '0; rd = '0; rs1_used = 0; rs2_used = 0; wr_en = 0;
    op = '0; redir_ex = 0; trap = 0; mvalid = 0; mdone = 0; clr = 0;
  endtask

  task automatic step(input string tag, input logic [6:0] e);
    exp_t t;
    t.tag = tag; t.exp = e;
    q.push_back(t);
    @(negedge clk);
    t = q.pop_front();
    tests++;
    assert (obs === t.exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", t.tag, obs, t.exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] e16, input logic [3:0] e4);
    tests += 2;
    assert (cnt16 === e16) else begin
      fails++;
      $error("FAIL %s cnt16 observed=%0d expected=%0d", tag, cnt16, e16);
    end
    assert (cnt4 === e4) else begin
      fails++;
      $error("FAIL %s cnt4 observed=%0d expected=%0d", tag, cnt4, e4);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    step("reset_out", NONE);
    chk_cnt("reset_cnt", 16'd0, 4'd0);
    rst_n = 1'b1;

    // load-use on rs1, then bubble in EX
    op = L_OP; rd = 5'd5; wr_en = 1; rs1 = 5'd5; rs1_used = 1; rs2 = 5'd7; rs2_used = 1;
    step("lu_rs1", LU);
    idle(); rs1 = 5'd5; rs1_used = 1;
    step("lu_bubble", NONE);
    op = L_OP; rd = 5'd0; wr_en = 1; rs1 = 5'd0; rs1_used = 1;
    step("lu_x0", NONE);
    idle(); op = L_OP; rd = 5'd9; wr_en = 1; rs2 = 5'd9; rs2_used = 1;
    step("lu_rs2", LU);
    rs2_used = 0;
    step("lu_rs2_unused", NONE);
    idle(); op = 7'b0110011; rd = 5'd9; wr_en = 1; rs1 = 5'd9; rs1_used = 1;
    step("lu_not_load", NONE);
    chk_cnt("cnt_after_lu", 16'd2, 4'd2);

    // 4-cycle memory wait
    idle(); mvalid = 1;
    for (int i = 0; i < 3; i++) step("mem_wait", ALLST);
    mdone = 1;
    step("mem_done", NONE);
    idle();
    chk_cnt("cnt_after_mem", 16'd5, 4'd5);

    // trap in cycle 2 of a 4-cycle wait
    mvalid = 1;
    step("trapw_c1", ALLST);
    trap = 1;
    step("trapw_c2", ALLST);
    trap = 0;
    step("trapw_c3", ALLST);
    mdone = 1;
    step("trapw_done", REDIR);
    idle();
    step("trapw_after", NONE);
    chk_cnt("cnt_after_trapw", 16'd8, 4'd8);

    // trap on the completion cycle: redirect now, nothing pending
    mvalid = 1;
    step("trapc_wait", ALLST);
    mdone = 1; trap = 1;
    step("trapc_done", REDIR);
    idle(); mvalid = 1; mdone = 1;
    step("trapc_nopend", NONE);
    idle();

    // redirect/trap beat load-use in S_RUN
    op = L_OP; rd = 5'd3; wr_en = 1; rs1 = 5'd3; rs1_used = 1; redir_ex = 1;
    step("prio_redir_lu", REDIR);
    redir_ex = 0; trap = 1;
    step("prio_trap_lu", REDIR);
    chk_cnt("cnt_after_prio", 16'd9, 4'd9);

    // load-use evaluated on completion cycle
    idle(); mvalid = 1;
    step("mlu_wait", ALLST);
    mdone = 1; op = L_OP; rd = 5'd4; wr_en = 1; rs2 = 5'd4; rs2_used = 1;
    step("mlu_done", LU);
    idle();
    chk_cnt("cnt_after_mlu", 16'd11, 4'd11);

    // mem wait beats trap in S_RUN; trap held pending
    mvalid = 1; trap = 1;
    step("mtrap_start", ALLST);
    trap = 0; mdone = 1;
    step("mtrap_done", REDIR);
    idle();

    // reset in S_MEM with a pending trap
    mvalid = 1; trap = 1;
    step("rst_wait1", ALLST);
    trap = 0;
    step("rst_wait2", ALLST);
    idle(); rst_n = 1'b0;
    step("rst_mid_out", NONE);
    chk_cnt("rst_mid_cnt", 16'd0, 4'd0);
    rst_n = 1'b1; mvalid = 1; mdone = 1;
    step("rst_discard", NONE);
    idle();

    // saturation of the narrow counter
    mvalid = 1;
    for (int i = 0; i < 20; i++) step("sat_wait", ALLST);
    chk_cnt("cnt_sat", 16'd20, 4'hF);
    clr = 1;
    step("clr_wait", ALLST);
    chk_cnt("cnt_clr", 16'd0, 4'd0);
    clr = 0; mdone = 1;
    step("clr_done", NONE);
    chk_cnt("cnt_hold", 16'd0, 4'd0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the RV32I_Zicsr 5-stage core. It sequences the IF/ID/EX/MEM pipeline registers around the forwarding unit: load-use bubbles, multi-cycle data-memory waits, branch/jump redirects and CSR traps. It sits beside the forwarding unit and drives the stall/flush enables of every pipeline register, plus a saturating stall-cycle counter for performance debug.

## Interface
- CNT_W, 16, width of stall-cycle counter
- i_clk  in  1  core clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_rs1_addr_id  in  `XADDR  rs1 address of instruction in ID
- i_rs2_addr_id  in  `XADDR  rs2 address of instruction in ID
- i_rs1_used_id  in  1  ID instruction reads rs1
- i_rs2_used_id  in  1  ID instruction reads rs2
- i_opcode_ex  in  `OPLEN  opcode of instruction in EX
- i_rd_addr_ex  in  `XADDR  rd address of instruction in EX
- i_rd_ex_wr_en  in  1  EX instruction writes register file
- i_redirect_ex  in  1  taken branch/JAL/JALR resolved in EX (held stable while EX stalled)
- i_trap  in  1  single-cycle pulse from CSR unit: exception, interrupt or MRET
- i_mem_req_valid  in  1  MEM stage has an outstanding load/store
- i_mem_req_complete  in  1  data memory finished the MEM-stage request this cycle
- i_cnt_clr  in  1  synchronous clear of stall counter
- or_stall_if, or_stall_id, or_stall_ex, or_stall_mem  out  1 each  hold the named pipeline register
- or_flush_id, or_flush_ex  out  1 each  load a bubble (NOP, wr_en=0) into the named register
- or_redirect  out  1  PC mux selects branch/trap target this cycle
- or_stall_cnt  out  CNT_W  stall cycles counted since reset/clear

## Operation
- States: S_RUN, S_MEM. Registers: state, trap_pend, or_stall_cnt.
- Load-use: lu = (i_opcode_ex==`L_OP) & i_rd_ex_wr_en & (i_rd_addr_ex!=0) & ((i_rs1_used_id & rs1_id==rd_ex) | (i_rs2_used_id & rs2_id==rd_ex)).
- mem_wait = i_mem_req_valid & ~i_mem_req_complete.
- S_RUN, priority high to low (all outputs combinational from state/inputs):
  - mem_wait: all four stalls=1, no flush; next S_MEM; i_trap sets trap_pend.
  - i_trap or i_redirect_ex: or_redirect=1, or_flush_id=1, or_flush_ex=1, no stalls; lu ignored.
  - lu: or_stall_if=1, or_stall_id=1, or_flush_ex=1 (one bubble); stays S_RUN.
  - else all outputs 0.
- S_MEM: all four stalls=1 while ~i_mem_req_complete; i_trap sets trap_pend. On i_mem_req_complete: stalls=0, next S_RUN; if trap_pend or i_trap or i_redirect_ex: or_redirect, or_flush_id, or_flush_ex=1 and trap_pend cleared; otherwise lu evaluated as in S_RUN.
- Counter: +1 each cycle or_stall_if=1; saturates at all-ones; i_cnt_clr wins over increment.
- Forwarding handles EX-stage hazards after the load-use bubble; this block never forwards data.

## Timing
- Reset (async, i_rst_n=0): state=S_RUN, trap_pend=0, or_stall_cnt=0; all 1-bit outputs 0 (combinational from reset state).
- Stall/flush/redirect are zero-latency (same cycle as cause); state, trap_pend and counter update next edge.
- Load-use costs exactly one bubble; the following cycle lu is false because EX holds the bubble.
- Memory wait of N cycles (complete on N-th): stalls asserted N-1 cycles.
- i_trap arriving in the same cycle as i_mem_req_complete: redirect applied that cycle, trap_pend not set.
- Reset asserted mid-S_MEM: returns to S_RUN, pending trap discarded.
- Counter at all-ones with stall: holds all-ones.

## Structure
- `L_OP, `XADDR, `OPLEN, `XLEN remain in header.vh; add state encodings `HZ_S_RUN=1'b0, `HZ_S_MEM=1'b1 there.
- Single module; no sub-module (stall counter inline).

## Test plan
- Reset: i_rst_n=0 during S_MEM with trap_pend=1 -> all outputs 0, cnt=0, S_RUN after release.
- Load-use: EX lw x5, ID add x6,x5,x7 (rs1_used) -> one cycle stall_if/id=1, flush_ex=1; next cycle all 0; rd=x0 case -> no stall.
- Mem wait: i_mem_req_valid=1, complete after 4 cycles -> four stalls high 3 cycles, cnt=3.
- Trap during wait: i_trap pulse in cycle 2 of 4-cycle wait -> no redirect until complete cycle, then redirect+flush_id+flush_ex for 1 cycle.
- Priority: i_redirect_ex and lu same cycle in S_RUN -> redirect+flushes, no stall_if.
- Counter: force CNT_W=4, 20 stall cycles -> cnt=4'hF; i_cnt_clr with stall -> 0.
